sample_serializer: RTL
======================

Name: sample_serializer

Overview:
Consumer end of the generate_next / sample_ready / sample handshake used by the sample generators (sine table reader and similar).
- Once per audio frame, pulses generate_next to request a sample and captures the returned sample within a bounded window.
- Shifts the captured sample out MSB-first on a serial DAC link (sclk, lrclk, sdata).
- Detects and counts underruns (sample not returned in time).

Parameters:
SAMPLE_WIDTH, 16, bits per sample; matches producer sample width.
CLKS_PER_BIT, 4, clk cycles per serial bit; even, >= 2.
BITS_PER_FRAME, 32, bit periods per frame; >= SAMPLE_WIDTH; BITS_PER_FRAME*CLKS_PER_BIT > TIMEOUT+2.
TIMEOUT, 8, cycles after the generate_next pulse during which sample_ready is accepted.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
sample_ready  input  1  producer strobe; sample valid this cycle
sample  input  SAMPLE_WIDTH  two's-complement sample from producer
generate_next  output  1  one-cycle request to producer
sclk  output  1  serial bit clock
lrclk  output  1  frame/word clock
sdata  output  1  serial data, MSB first
underrun  output  1  one-cycle pulse at frame start when no fresh sample was available
underrun_count  output  8  saturating underrun counter

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- While reset is low, all outputs are 0. This includes generate_next, sclk, lrclk, sdata, underrun and underrun_count. The following are also cleared: bit_phase, bit_cnt, shift register, holding register and last-sample register. holding_valid is set to 1, so frame 0 sends zero without an underrun. FSM goes to IDLE.
- Counters:
  - bit_phase counts 0..CLKS_PER_BIT-1.
  - bit_cnt counts 0..BITS_PER_FRAME-1, advancing when bit_phase wraps; it wraps to 0 (the next frame start).
  - The first cycle after reset release is frame start: bit_cnt=0, bit_phase=0.
- sclk = 0 for bit_phase < CLKS_PER_BIT/2, else 1. sdata changes only when bit_phase = 0 (sclk falling).
- lrclk = 0 for bit_cnt < BITS_PER_FRAME/2, else 1.
- Frame start (bit_cnt=0, bit_phase=0):
  - If holding_valid: shift register <= holding register; last-sample <= holding; holding_valid <= 0.
  - Else: underrun pulses for 1 cycle; underrun_count increments, saturating at 255; shift register <= last-sample.
  - sdata for bit k of a frame (k < SAMPLE_WIDTH) = loaded sample bit [SAMPLE_WIDTH-1-k]. Bits k >= SAMPLE_WIDTH are 0.
- Request FSM:
  - IDLE -> REQ at frame start.
  - REQ: generate_next = 1 for exactly this one cycle (bit_cnt=0, bit_phase=1). Go to WAIT with wait counter = 0.
  - WAIT: wait counter increments each cycle.
    - If sample_ready = 1 while counter < TIMEOUT: holding <= sample, holding_valid <= 1, go to IDLE.
    - If counter reaches TIMEOUT without sample_ready: go to IDLE. holding_valid stays 0, so an underrun occurs at the next frame start.
- Nominal producer latency is 2 cycles after generate_next. Any latency of 1..TIMEOUT cycles is accepted.
- The sample requested in frame N is transmitted in frame N+1. Pipeline latency is one frame.
- sample_ready outside WAIT (early, late, spurious or duplicate) is ignored. Only the first strobe in WAIT is captured.
- A frame start while in WAIT cannot occur, given the parameter constraint.
- Reset asserted mid-frame clears everything immediately. After release, operation restarts at frame 0 and underrun_count = 0.

Optional Feature:
UNDERRUN_MUTE_EN
- Defined: on underrun, the shift register loads 0 (silence) and last-sample is cleared to 0.
- Undefined: on underrun, the last transmitted sample is repeated.
- underrun and underrun_count behave identically in both builds.

Test Plan:
Defaults: CLKS_PER_BIT=4, BITS_PER_FRAME=32, TIMEOUT=8; frame = 128 cycles.
- Reset release, no producer activity -> generate_next high at cycles 1, 129, 257. Frame 0 sdata all 0. underrun pulses at cycles 128 and 256; underrun_count = 2 after cycle 256.
- Producer returns sample_ready 2 cycles after each request, sample = 16'hA5C3 -> next frame sdata = 1010_0101_1100_0011 then 16 zeros. sclk period 4 cycles; lrclk toggles every 64 cycles; underrun stays 0.
- Sample 16'h7FFF sent, then no sample_ready in the next frame -> underrun pulse at frame start, underrun_count +1. Frame repeats 16'h7FFF; it is 16'h0000 with UNDERRUN_MUTE_EN.
- sample_ready at request+12 (beyond TIMEOUT) with 16'h1234 -> ignored; underrun next frame. Strobes at request+2 (16'h8000) and request+3 (16'h0001) -> 16'h8000 sent: MSB 1, then 31 zeros.
- Reset driven low at frame bit 10 -> all outputs 0 in the same cycle without a clock edge. After release, generate_next at cycle 1 again and underrun_count = 0.
- 300 consecutive underrun frames -> underrun_count saturates at 255 and holds.

Source files
------------

// File: rtl/sample_serializer.sv
// Requests one sample per frame over the generate_next/sample_ready handshake and sends it MSB-first on sclk/lrclk/sdata.
// Build option: define UNDERRUN_MUTE_EN to send silence on underrun instead of repeating the last sample.
module sample_serializer #(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int CLKS_PER_BIT   = 4,
    parameter int BITS_PER_FRAME = 32,
    parameter int TIMEOUT        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    generate_next,
    output logic                    sclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underrun,
    output logic [7:0]              underrun_count
);

    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (BITS_PER_FRAME > 1) ? $clog2(BITS_PER_FRAME) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BC_LAST = BW'(BITS_PER_FRAME - 1);
    localparam logic [BW-1:0] BC_HALF = BW'(BITS_PER_FRAME / 2);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           bit_phase;
    logic [BW-1:0]           bit_cnt;
    logic [WW-1:0]           wait_cnt;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] holding;
    logic [SAMPLE_WIDTH-1:0] last_sample;
    logic [SAMPLE_WIDTH-1:0] repeat_value;
    logic [SAMPLE_WIDTH-1:0] load_value;
    logic                    holding_valid;
    logic                    frame_start;
    logic                    bit_end;
    logic                    capture;

    assign frame_start = (bit_cnt == '0) && (bit_phase == '0);
    assign bit_end     = (bit_phase == PH_LAST);
    assign sclk        = (bit_phase >= PH_HALF);
    assign lrclk       = (bit_cnt >= BC_HALF);
    assign underrun    = frame_start && !holding_valid;

`ifdef UNDERRUN_MUTE_EN
    assign repeat_value = '0;
`else
    assign repeat_value = last_sample;
`endif
    assign load_value = holding_valid ? holding : repeat_value;

    // The shift register is loaded at the end of the frame-start cycle, so the MSB is bypassed during that cycle.
    assign sdata = frame_start ? load_value[SAMPLE_WIDTH-1] : shift_reg[SAMPLE_WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_phase <= '0;
            bit_cnt   <= '0;
        end else if (bit_end) begin
            bit_phase <= '0;
            bit_cnt   <= (bit_cnt == BC_LAST) ? '0 : bit_cnt + 1'b1;
        end else begin
            bit_phase <= bit_phase + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg      <= '0;
            holding        <= '0;
            last_sample    <= '0;
            holding_valid  <= 1'b1;
            underrun_count <= '0;
        end else begin
            if (frame_start) begin
                shift_reg     <= load_value;
                last_sample   <= load_value;
                holding_valid <= 1'b0;
                if (!holding_valid && underrun_count != 8'hFF)
                    underrun_count <= underrun_count + 8'd1;
            end else if (bit_end) begin
                shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], 1'b0};
            end
            // Capture only happens in WAIT, which never overlaps a frame start.
            if (capture) begin
                holding       <= sample;
                holding_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == REQ)
                wait_cnt <= '0;
            else if (state_q == WAIT)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        generate_next = 1'b0;
        capture       = 1'b0;
        case (state_q)
            IDLE: if (frame_start) state_d = REQ;
            REQ: begin
                generate_next = 1'b1;
                state_d       = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LIMIT) begin
                    state_d = IDLE;
                end else if (sample_ready) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
